// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the scheduler state type.
package vga_pkg;

  // 640x480@60 line timing, in pixel clocks
  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int H_TOT_DEF  = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  // 640x480@60 frame timing, in lines
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;
  localparam int V_TOT_DEF  = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Width of the hpos/vpos position counters
  localparam int POS_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PEND   = 2'd2,
    COMMIT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters with registered sync, blanking and frame-count decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOT - 1);
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOT - 1);
  localparam logic [POS_W-1:0] H_VEND = POS_W'(H_VIS);
  localparam logic [POS_W-1:0] V_VEND = POS_W'(V_VIS);
  localparam logic [POS_W-1:0] H_SS   = POS_W'(H_VIS + H_FP);
  localparam logic [POS_W-1:0] H_SE   = POS_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] V_SS   = POS_W'(V_VIS + V_FP);
  localparam logic [POS_W-1:0] V_SE   = POS_W'(V_VIS + V_FP + V_SYNC);

  // After reset release the first clock parks at (0,0) so the decoded
  // outputs describe pixel (0,0) before counting starts.
  logic             started;
  logic [POS_W-1:0] h_nxt;
  logic [POS_W-1:0] v_nxt;
  logic             wrap_frame;

  // Next raster position; sync/blank flags are decoded from it so they line up with hpos/vpos
  always_comb begin
    h_nxt      = hpos;
    v_nxt      = vpos;
    wrap_frame = 1'b0;
    if (!started) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (hpos == H_LAST) begin
      h_nxt = '0;
      if (vpos == V_LAST) begin
        v_nxt      = '0;
        wrap_frame = 1'b1;
      end else begin
        v_nxt = vpos + POS_W'(1);
      end
    end else begin
      h_nxt = hpos + POS_W'(1);
    end
  end

  // Register position, active-low syncs, visible-area flag and completed-frame count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started    <= 1'b0;
      hpos       <= '0;
      vpos       <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      display_on <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      started    <= 1'b1;
      hpos       <= h_nxt;
      vpos       <= v_nxt;
      hsync      <= !((h_nxt >= H_SS) && (h_nxt < H_SE));
      vsync      <= !((v_nxt >= V_SS) && (v_nxt < V_SE));
      display_on <= (h_nxt < H_VEND) && (v_nxt < V_VEND);
      if (wrap_frame) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/vga_frame_sched.sv
// VGA timing plus a mode scheduler that only commits mode changes at vblank.
module vga_frame_sched
  import vga_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       ui_in,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic [2:0]       mode,
  output logic             mode_stb,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOT - 1);
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOT - 1);
  localparam logic [POS_W-1:0] V_BLNK = POS_W'(V_VIS);

  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .hpos       (hpos),
    .vpos       (vpos),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .frame_cnt  (frame_cnt)
  );

  sched_state_t state;
  logic [2:0]   req;
  logic [7:0]   auto_cnt;
  logic         auto_q;
  logic         auto_on;
  logic [7:0]   period;
  logic         vblank_start;
  logic         frame_end;
  logic [2:0]   want;
  logic         run_trigger;
  logic         unused_ui;

  assign unused_ui    = ui_in[3];
  assign auto_on      = ui_in[7];
  assign period       = 8'd1 << ui_in[6:4];
  assign vblank_start = (hpos == '0) && (vpos == V_BLNK);
  assign frame_end    = (hpos == H_LAST) && (vpos == V_LAST);
  // Auto mode always asks for the next pattern; manual mode asks for ui_in[2:0]
  assign want         = auto_on ? (mode + 3'd1) : ui_in[2:0];
  assign run_trigger  = auto_on ? (auto_cnt >= period) : (ui_in[2:0] != mode);

  // Frames elapsed since the last commit or since auto-cycle was switched on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_q   <= 1'b0;
      auto_cnt <= '0;
    end else begin
      auto_q <= auto_on;
      if (ena) begin
        if ((auto_on && !auto_q) || (state == COMMIT)) begin
          auto_cnt <= '0;
        end else if (frame_end && (auto_cnt != 8'hFF)) begin
          auto_cnt <= auto_cnt + 8'd1;
        end
      end
    end
  end

  // Scheduler: latch a request, hold it until the first vblank cycle, then commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req      <= '0;
      mode     <= '0;
      mode_stb <= 1'b0;
    end else begin
      mode_stb <= 1'b0;
      if (!ena) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= RUN;
          RUN: begin
            if (run_trigger) begin
              req   <= want;
              state <= PEND;
            end
          end
          PEND: begin
            // The request seen during the vblank cycle itself is not used;
            // the value latched on the previous cycle is committed.
            if (vblank_start) begin
              mode     <= req;
              mode_stb <= 1'b1;
              state    <= COMMIT;
            end else if (want == mode) begin
              state <= RUN;
            end else begin
              req <= want;
            end
          end
          COMMIT:  state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_sched.sv
// Bench for vga_frame_sched using a reduced raster (24x18 clocks per frame).
module tb_vga_frame_sched;

  localparam int HV = 16, HF = 2, HS = 4, HB = 2;
  localparam int VV = 12, VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [9:0] hpos, vpos;
  logic       hsync, vsync, display_on;
  logic [2:0] mode;
  logic       mode_stb;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int edges;

  vga_frame_sched #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .ui_in      (ui_in),
    .hpos       (hpos),
    .vpos       (vpos),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .mode       (mode),
    .mode_stb   (mode_stb),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; edge n shows raster index n-1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  // Expected {hpos, vpos, hsync, vsync, display_on, frame_cnt} at raster index p
  function automatic logic [30:0] exp_vec(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    exp_vec = {10'(h), 10'(v),
               !((h >= HV + HF) && (h < HV + HF + HS)),
               !((v >= VV + VF) && (v < VV + VF + VS)),
               ((h < HV) && (v < VV)),
               8'(p / FT)};
  endfunction

  // Advance (on negedges) to the next occurrence of raster position (h, v)
  task automatic goto(input int h, input int v);
    int n;
    n = ((v * HT + h) - ((edges - 1) % FT) + FT) % FT;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({hpos, vpos, hsync, vsync, display_on} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_timing: got %h expected %h", {hpos, vpos, hsync, vsync, display_on}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b0});
    end
    checks++;
    if ({mode, mode_stb, frame_cnt} !== {3'd0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_mode: got %h expected %h", {mode, mode_stb, frame_cnt}, {3'd0, 1'b0, 8'd0});
    end
    rst_n = 1'b1; ena = 1'b1;
    @(negedge clk);
    checks++;
    if ({hpos, vpos, hsync, vsync, display_on, frame_cnt} !== exp_vec(0)) begin
      errors++;
      $display("FAIL first_pixel: got %h expected %h", {hpos, vpos, hsync, vsync, display_on, frame_cnt}, exp_vec(0));
    end
  endtask

  task automatic test_timing();
    int   pulses [5];
    logic hs_prev;
    int   p;
    for (int i = 0; i < 5; i++) pulses[i] = 0;
    hs_prev = hsync;
    for (int k = 0; k < 5 * FT; k++) begin
      p = edges - 1;
      checks++;
      if ({hpos, vpos, hsync, vsync, display_on, frame_cnt} !== exp_vec(p)) begin
        errors++;
        $display("FAIL timing p=%0d: got %h expected %h", p, {hpos, vpos, hsync, vsync, display_on, frame_cnt}, exp_vec(p));
      end
      if (hs_prev && !hsync) pulses[p / FT]++;
      hs_prev = hsync;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pulses[i] !== VT) begin
        errors++;
        $display("FAIL hsync_pulses frame %0d: got %0d expected %0d", i, pulses[i], VT);
      end
    end
    checks++;
    if (frame_cnt !== 8'd5) begin
      errors++;
      $display("FAIL frame_cnt_5: got %0d expected 5", frame_cnt);
    end
  endtask

  // Manual requests, optionally overwritten while pending; the last one wins at vblank
  task automatic test_manual();
    logic [2:0] old, m1, m2, expm;
    int r1, r2;
    bit two;
    for (int it = 0; it < 3; it++) begin
      old = mode;
      m1  = old + 3'($urandom_range(1, 7));
      m2  = old + 3'($urandom_range(1, 7));
      two = 1'($urandom_range(0, 1));
      r1  = int'($urandom_range(1, VV / 2 - 1));
      r2  = int'($urandom_range(VV / 2, VV - 1));
      expm = two ? m2 : m1;
      goto(0, r1);
      ui_in = {1'b0, 3'($urandom), 1'b0, m1};
      for (int k = 0; k < (VV - r1) * HT; k++) begin
        if (two && (k == (r2 - r1) * HT)) ui_in = {1'b0, 3'($urandom), 1'b0, m2};
        checks++;
        if ({mode, mode_stb} !== {old, 1'b0}) begin
          errors++;
          $display("FAIL manual_hold it=%0d k=%0d: got %h expected %h", it, k, {mode, mode_stb}, {old, 1'b0});
        end
        @(negedge clk);
      end
      checks++;
      if ({mode, mode_stb} !== {old, 1'b0}) begin
        errors++;
        $display("FAIL manual_at_vblank it=%0d: got %h expected %h", it, {mode, mode_stb}, {old, 1'b0});
      end
      @(negedge clk);
      checks++;
      if ({mode, mode_stb} !== {expm, 1'b1}) begin
        errors++;
        $display("FAIL manual_commit it=%0d: got %h expected %h", it, {mode, mode_stb}, {expm, 1'b1});
      end
      @(negedge clk);
      checks++;
      if ({mode, mode_stb} !== {expm, 1'b0}) begin
        errors++;
        $display("FAIL manual_stb_width it=%0d: got %h expected %h", it, {mode, mode_stb}, {expm, 1'b0});
      end
    end
  endtask

  // A request withdrawn before vblank never commits
  task automatic test_cancel();
    logic [2:0] old, m;
    old = mode;
    m   = old + 3'($urandom_range(1, 7));
    goto(0, 3);
    ui_in = {5'd0, m};
    goto(0, 6);
    ui_in = {5'd0, old};
    for (int k = 0; k < FT; k++) begin
      checks++;
      if ({mode, mode_stb} !== {old, 1'b0}) begin
        errors++;
        $display("FAIL cancel k=%0d: got %h expected %h", k, {mode, mode_stb}, {old, 1'b0});
      end
      @(negedge clk);
    end
  endtask

  // Dropping ena while pending discards the request but not the raster
  task automatic test_ena_pend();
    logic [2:0] old, m;
    old = mode;
    m   = old + 3'($urandom_range(1, 7));
    goto(0, 3);
    ui_in = {5'd0, m};
    goto(0, 6);
    ena = 1'b0;
    for (int k = 0; k < FT; k++) begin
      checks++;
      if ({mode, mode_stb, hpos, vpos, hsync, vsync, display_on, frame_cnt} !== {old, 1'b0, exp_vec(edges - 1)}) begin
        errors++;
        $display("FAIL ena_low k=%0d: got %h expected %h", k, {mode, mode_stb, hpos, vpos, hsync, vsync, display_on, frame_cnt}, {old, 1'b0, exp_vec(edges - 1)});
      end
      @(negedge clk);
    end
    ena = 1'b1;
    goto(0, VV);
    checks++;
    if ({mode, mode_stb} !== {old, 1'b0}) begin
      errors++;
      $display("FAIL ena_resume_hold: got %h expected %h", {mode, mode_stb}, {old, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({mode, mode_stb} !== {m, 1'b1}) begin
      errors++;
      $display("FAIL ena_resume_commit: got %h expected %h", {mode, mode_stb}, {m, 1'b1});
    end
  endtask

  // Asynchronous reset mid-frame, then a clean restart from (0,0)
  task automatic test_reset_mid();
    bit seen;
    goto(int'($urandom_range(0, HT - 1)), 8);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({hpos, vpos, hsync, vsync, display_on, mode, mode_stb, frame_cnt} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", {hpos, vpos, hsync, vsync, display_on, mode, mode_stb, frame_cnt}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'd0});
    end
    ui_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    seen = 1'b0;
    for (int k = 0; k < FT; k++) begin
      checks++;
      if ({mode, mode_stb, hpos, vpos, hsync, vsync, display_on, frame_cnt} !== {3'd0, 1'b0, exp_vec(k)}) begin
        errors++;
        $display("FAIL restart k=%0d: got %h expected %h", k, {mode, mode_stb, hpos, vpos, hsync, vsync, display_on, frame_cnt}, {3'd0, 1'b0, exp_vec(k)});
      end
      if (!vsync && !seen) begin
        seen = 1'b1;
        checks++;
        if ({hpos, vpos} !== {10'd0, 10'(VV + VF)}) begin
          errors++;
          $display("FAIL first_vsync: got h=%0d v=%0d expected h=0 v=%0d", hpos, vpos, VV + VF);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL first_vsync: got none expected one within a frame");
    end
  endtask

  // Auto-cycle with period 2: first step two frames after enabling, then every second vblank
  task automatic test_auto();
    logic [2:0] expm;
    bit commit;
    expm = mode;
    goto(0, 3);
    ui_in = 8'h90;
    for (int k = 0; k <= 16; k++) begin
      goto(0, VV);
      checks++;
      if ({mode, mode_stb} !== {expm, 1'b0}) begin
        errors++;
        $display("FAIL auto_hold k=%0d: got %h expected %h", k, {mode, mode_stb}, {expm, 1'b0});
      end
      @(negedge clk);
      commit = (k >= 2) && (k % 2 == 0);
      if (commit) expm = expm + 3'd1;
      checks++;
      if ({mode, mode_stb} !== {expm, commit}) begin
        errors++;
        $display("FAIL auto_step k=%0d: got %h expected %h", k, {mode, mode_stb}, {expm, commit});
      end
    end
    ui_in = 8'h00;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_manual();
    test_cancel();
    test_ena_pend();
    test_reset_mid();
    test_auto();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
